// File: rtl/universal_counter_4b.sv
// -----------------------------------------------------------------------------
// universal_counter_4b
//
// Loadable, bidirectional, wrapping up/down counter with hold.
//
// Ports
//   data     in   WIDTH  parallel load value, captured when load = 1
//   load     in   1      synchronous load enable (beats pause and incr)
//   incr     in   1      direction: 1 = up, 0 = down
//   pause    in   1      hold the current value (ignored while load = 1)
//   clock    in   1      rising-edge clock
//   counter  out  WIDTH  registered count
//   reset_n  in   1      asynchronous active-low clear
//
// Reset sits last in the port list so older positional hookups of the first
// six ports stay valid.
// -----------------------------------------------------------------------------
module universal_counter_4b #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             incr,
    input  logic             pause,
    input  logic             clock,
    output logic [WIDTH-1:0] counter,
    input  logic             reset_n
);

    // Next-state selection, in priority order: load, hold, up, down.
    // Unsigned WIDTH-bit arithmetic wraps silently in both directions.
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = counter;
        if (load)
            count_next = data;
        else if (pause)
            count_next = counter;
        else if (incr)
            count_next = counter + WIDTH'(1);
        else
            count_next = counter - WIDTH'(1);
    end

    // The output is the register itself; no input reaches counter without
    // passing through this flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            counter <= '0;
        else
            counter <= count_next;
    end

endmodule

// File: tb/tb_universal_counter_4b.sv
// -----------------------------------------------------------------------------
// tb_universal_counter_4b
//
// Directed-vector bench for universal_counter_4b. Inputs change 1 time unit
// after each rising edge; the counter is sampled at that same point, so every
// sample reflects exactly the edge just taken.
// -----------------------------------------------------------------------------
module tb_universal_counter_4b;

    logic [3:0] data;
    logic       load;
    logic       incr;
    logic       pause;
    logic       clock;
    logic [3:0] counter;
    logic       reset_n;

    int checks   = 0;
    int failures = 0;

    universal_counter_4b #(.WIDTH(4)) dut (
        .data    (data),
        .load    (load),
        .incr    (incr),
        .pause   (pause),
        .clock   (clock),
        .counter (counter),
        .reset_n (reset_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input logic [3:0] expected, input string tag);
        checks++;
        assert (counter === expected)
        else begin
            failures++;
            $error("FAIL %s: counter=%0d expected=%0d", tag, counter, expected);
        end
    endtask

    // Take one rising edge, then sample just after it.
    task automatic step(input logic [3:0] expected, input string tag);
        @(posedge clock);
        #1;
        check(expected, tag);
    endtask

    initial begin
        data    = 4'd0;
        load    = 1'b0;
        incr    = 1'b1;
        pause   = 1'b0;
        reset_n = 1'b0;

        // Reset state, held across edges
        #2;
        check(4'd0, "reset_async");
        step(4'd0, "reset_hold_a");
        step(4'd0, "reset_hold_b");

        // Release between edges; first edge counts from 0
        #2;
        reset_n = 1'b1;
        step(4'd1, "rel_up1");
        step(4'd2, "rel_up2");
        step(4'd3, "rel_up3");
        step(4'd4, "rel_up4");
        step(4'd5, "rel_up5");

        // Mid-count reset between edges clears immediately
        #2;
        reset_n = 1'b0;
        #1;
        check(4'd0, "midreset_async");
        step(4'd0, "midreset_hold");
        #2;
        reset_n = 1'b1;

        // Up-count from 0 to 5
        step(4'd1, "up1");
        step(4'd2, "up2");
        step(4'd3, "up3");
        step(4'd4, "up4");
        step(4'd5, "up5");

        // Load 12, then count up through the wrap
        load = 1'b1; data = 4'b1100;
        step(4'd12, "load12");
        load = 1'b0;
        step(4'd13, "up13");
        step(4'd14, "up14");
        step(4'd15, "up15");
        step(4'd0,  "up_wrap0");
        step(4'd1,  "up_wrap1");

        // Load 2, count down through the wrap, then flip direction
        load = 1'b1; data = 4'd2;
        step(4'd2, "load2");
        load = 1'b0; incr = 1'b0;
        step(4'd1,  "dn1");
        step(4'd0,  "dn0");
        step(4'd15, "dn_wrap15");
        step(4'd14, "dn14");
        incr = 1'b1;
        step(4'd15, "dir_flip15");

        // Pause at 9 while incr toggles
        load = 1'b1; data = 4'd9;
        step(4'd9, "load9");
        load = 1'b0; pause = 1'b1; incr = 1'b0;
        step(4'd9, "pause_a");
        incr = 1'b1;
        step(4'd9, "pause_b");
        incr = 1'b0;
        step(4'd9, "pause_c");
        pause = 1'b0; incr = 1'b1;
        step(4'd10, "unpause10");

        // Load beats pause
        pause = 1'b1; load = 1'b1; data = 4'b0111;
        step(4'd7, "load_over_pause");
        pause = 1'b0; load = 1'b0; incr = 1'b0;
        step(4'd6, "dn_after_load");

        // Held load tracks data; no counting in either direction
        load = 1'b1; incr = 1'b1; data = 4'd3;
        step(4'd3, "cload3");
        incr = 1'b0; data = 4'd8;
        step(4'd8, "cload8");
        incr = 1'b1; data = 4'd15;
        step(4'd15, "cload15");
        load = 1'b0;
        step(4'd0, "after_cload_wrap");

        // Input wiggles between edges have no effect
        data = 4'd5; load = 1'b1;
        #2;
        load = 1'b0;
        check(4'd0, "no_async_load");
        step(4'd1, "between_edges_up");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
